// File: rtl/glut_pkg.sv
// glut_pkg: shared definitions for the GLUT stage scheduler.
//   - Op-code constants accepted on cmd_op.
//   - Scheduler FSM state enum.
//   - DATA_NUM_DEF: default beats per stage when cmd_len is 0.
//   - Helpers to classify op codes (valid / two-operand).
package glut_pkg;

    localparam logic [3:0] OP_SILU = 4'd3;
    localparam logic [3:0] OP_GELU = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_MUL  = 4'd6;

    localparam int unsigned DATA_NUM_DEF = 192;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CFG   = 3'd1,
        START = 3'd2,
        FEED  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } glut_state_e;

    function automatic logic op_is_valid(input logic [3:0] op);
        return (op == OP_SILU) || (op == OP_GELU) || (op == OP_ADD) || (op == OP_MUL);
    endfunction

    // Two-operand ops consume the B stream as well as A.
    function automatic logic op_is_binary(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/glut_stage_sched.sv
// glut_stage_sched: sequences one array stage per accepted command.
//   IDLE -> CFG (2 cycles, stage_start low) -> START (2 cycles, stage_start high)
//   -> FEED (issue len beats) -> DRAIN (wait for len results) -> DONE (1 cycle).
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   cmd_valid/cmd_ready, cmd_op/len  command handshake; len 0 means DATA_NUM
//   src_a_*, src_b_*                 operand streams (B used by ADD/MUL only)
//   arr_stage_start, arr_configs     array stage control
//   arr_at*, arr_bt*                 registered operand beats to the array
//   arr_result_tvalid                array result strobe
//   busy, done, err_op               status
//   perf_cycles                      stage cycle count, only with GLUT_SCHED_PERF_EN defined
module glut_stage_sched
    import glut_pkg::*;
#(
    parameter int unsigned DATA_NUM = 10'd192,
    parameter int unsigned LEN_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             src_a_valid,
    output logic             src_a_ready,
    input  logic [63:0]      src_a_data,
    input  logic             src_b_valid,
    output logic             src_b_ready,
    input  logic [63:0]      src_b_data,
    output logic             arr_stage_start,
    output logic [3:0]       arr_configs,
    output logic             arr_atvalid,
    output logic [63:0]      arr_atdata,
    output logic             arr_btvalid,
    output logic [63:0]      arr_btdata,
    input  logic             arr_result_tvalid,
    output logic             busy,
    output logic             done,
    output logic             err_op
`ifdef GLUT_SCHED_PERF_EN
    ,
    output logic [31:0]      perf_cycles
`endif
);

    glut_state_e      state_q, state_d;
    logic [1:0]       wait_q, wait_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] issue_q, issue_d;
    logic [LEN_W-1:0] res_q, res_d;
    logic             cmd_hs;
    logic             cmd_ok;
    logic             bin_op;
    logic             beat;

    assign cmd_hs = cmd_valid && cmd_ready && (state_q == IDLE);
    assign cmd_ok = op_is_valid(cmd_op);
    assign bin_op = op_is_binary(arr_configs);

    // FEED always exits as the last beat issues, so no length compare is needed here.
    assign beat        = (state_q == FEED) && src_a_valid && (!bin_op || src_b_valid);
    assign src_a_ready = beat;
    assign src_b_ready = beat && bin_op;

    assign arr_stage_start = (state_q == START) || (state_q == FEED) || (state_q == DRAIN);
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        issue_d = issue_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (cmd_hs && cmd_ok) begin
                    state_d = CFG;
                    wait_d  = 2'd0;
                    issue_d = '0;
                    res_d   = '0;
                end
            end
            CFG: begin
                wait_d = wait_q + 2'd1;
                if (wait_q == 2'd1) begin
                    state_d = START;
                    wait_d  = 2'd0;
                end
            end
            START: begin
                wait_d = wait_q + 2'd1;
                if (wait_q == 2'd1) begin
                    state_d = FEED;
                    wait_d  = 2'd0;
                end
            end
            FEED: begin
                if (beat) begin
                    issue_d = issue_q + LEN_W'(1);
                    if (issue_d == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (res_q == len_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Results are counted independently of issue so a coincident strobe is never lost.
        if (((state_q == FEED) || (state_q == DRAIN)) && arr_result_tvalid && (res_q != len_q)) begin
            res_d = res_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_q      <= 2'd0;
            issue_q     <= '0;
            res_q       <= '0;
            len_q       <= '0;
            cmd_ready   <= 1'b0;
            err_op      <= 1'b0;
            arr_configs <= 4'd0;
            arr_atvalid <= 1'b0;
            arr_atdata  <= 64'd0;
            arr_btvalid <= 1'b0;
            arr_btdata  <= 64'd0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            issue_q     <= issue_d;
            res_q       <= res_d;
            cmd_ready   <= (state_d == IDLE);
            err_op      <= cmd_hs && !cmd_ok;
            if (cmd_hs && cmd_ok) begin
                arr_configs <= cmd_op;
                len_q       <= (cmd_len == '0) ? LEN_W'(DATA_NUM) : cmd_len;
            end
            arr_atvalid <= beat;
            arr_btvalid <= beat && bin_op;
            if (beat) begin
                arr_atdata <= src_a_data;
            end
            if (beat && bin_op) begin
                arr_btdata <= src_b_data;
            end
        end
    end

`ifdef GLUT_SCHED_PERF_EN
    // Counts every non-IDLE cycle of the stage; cleared only by the next accepted command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= 32'd0;
        end else if (cmd_hs && cmd_ok) begin
            perf_cycles <= 32'd0;
        end else if (state_q != IDLE) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_glut_stage_sched.sv
// tb_glut_stage_sched: scoreboard bench for glut_stage_sched (default build).
// Source handshakes push expected array beats; array beats pop and compare them.
module tb_glut_stage_sched;
    import glut_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [9:0]  cmd_len;
    logic        src_a_valid, src_a_ready;
    logic [63:0] src_a_data;
    logic        src_b_valid, src_b_ready;
    logic [63:0] src_b_data;
    logic        arr_stage_start;
    logic [3:0]  arr_configs;
    logic        arr_atvalid, arr_btvalid;
    logic [63:0] arr_atdata, arr_btdata;
    logic        arr_result_tvalid;
    logic        busy, done, err_op;

    glut_stage_sched dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_len          (cmd_len),
        .src_a_valid      (src_a_valid),
        .src_a_ready      (src_a_ready),
        .src_a_data       (src_a_data),
        .src_b_valid      (src_b_valid),
        .src_b_ready      (src_b_ready),
        .src_b_data       (src_b_data),
        .arr_stage_start  (arr_stage_start),
        .arr_configs      (arr_configs),
        .arr_atvalid      (arr_atvalid),
        .arr_atdata       (arr_atdata),
        .arr_btvalid      (arr_btvalid),
        .arr_btdata       (arr_btdata),
        .arr_result_tvalid(arr_result_tvalid),
        .busy             (busy),
        .done             (done),
        .err_op           (err_op)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Stimulus controls
    logic        a_en = 1'b0, b_en = 1'b0, b_alt = 1'b0, extra_res = 1'b0;
    logic        a_hs = 1'b0, b_hs = 1'b0;
    logic [3:0]  cur_op = 4'd0;
    int          res_delay = 5;

    // Scoreboard
    logic [63:0] qa[$], qb[$];
    int          qa_cyc[$], qb_cyc[$];
    int          res_due[$];

    // Per-stage observations
    int at_cnt, bt_cnt, bready_cnt, done_cnt, res_seen;
    int cmd_cyc, ss_rise, first_at, done_cyc, last_res_cyc;
    logic ss_prev = 1'b0;

    // Source / result driver: changes inputs 1 time unit after the rising edge.
    initial begin
        src_a_data        = 64'hA000_0000_0000_0000;
        src_b_data        = 64'hB000_0000_0000_0000;
        src_a_valid       = 1'b0;
        src_b_valid       = 1'b0;
        arr_result_tvalid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (a_hs) src_a_data = src_a_data + 64'd1;
            if (b_hs) src_b_data = src_b_data + 64'd3;
            src_a_valid = a_en;
            src_b_valid = b_en && (!b_alt || cyc[0]);
            if (res_due.size() > 0 && res_due[0] <= cyc) begin
                arr_result_tvalid = 1'b1;
                void'(res_due.pop_front());
            end else begin
                arr_result_tvalid = extra_res;
            end
        end
    end

    // Monitor on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            a_hs = src_a_valid && src_a_ready;
            b_hs = src_b_valid && src_b_ready;
            if (a_hs) begin
                qa.push_back(src_a_data);
                qa_cyc.push_back(cyc + 1);
            end
            if (b_hs) begin
                qb.push_back(src_b_data);
                qb_cyc.push_back(cyc + 1);
            end
            if (src_a_ready) check_val("a_rdy_needs_valid", src_a_valid, 1);
            if (src_b_ready) bready_cnt++;
            if (op_is_binary(cur_op) && (src_a_ready || src_b_ready)) begin
                check_val("ab_rdy_pair", src_b_ready, src_a_ready);
                check_val("b_rdy_needs_valid", src_b_valid, 1);
            end
            if (arr_atvalid) begin
                at_cnt++;
                if (first_at < 0) first_at = cyc;
                check_val("a_expected", qa.size() > 0, 1);
                if (qa.size() > 0) begin
                    check_val("a_data", arr_atdata, qa.pop_front());
                    check_val("a_latency", cyc, qa_cyc.pop_front());
                end
                res_due.push_back(cyc + res_delay);
            end
            if (arr_btvalid) begin
                bt_cnt++;
                check_val("b_expected", qb.size() > 0, 1);
                if (qb.size() > 0) begin
                    check_val("b_data", arr_btdata, qb.pop_front());
                    check_val("b_latency", cyc, qb_cyc.pop_front());
                end
            end
            if (op_is_binary(cur_op) && (arr_atvalid || arr_btvalid))
                check_val("ab_valid_pair", arr_btvalid, arr_atvalid);
            if (arr_result_tvalid) begin
                res_seen++;
                last_res_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check_val("ss_low_at_done", arr_stage_start, 0);
            end
            if (arr_stage_start && !ss_prev && ss_rise < 0) ss_rise = cyc;
            ss_prev = arr_stage_start;
            if (cmd_valid && cmd_ready) cmd_cyc = cyc;
        end else begin
            a_hs    = 1'b0;
            b_hs    = 1'b0;
            ss_prev = 1'b0;
        end
    end

    task automatic clear_stage();
        at_cnt = 0; bt_cnt = 0; bready_cnt = 0; done_cnt = 0; res_seen = 0;
        cmd_cyc = -1; ss_rise = -1; first_at = -1; done_cyc = -1; last_res_cyc = -1;
        qa.delete(); qb.delete(); qa_cyc.delete(); qb_cyc.delete(); res_due.delete();
    endtask

    task automatic send_cmd(input logic [3:0] op, input logic [9:0] len);
        @(posedge clk);
        #1;
        check_val("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [9:0] len, input logic alt,
                           input int delay);
        int   exp_n;
        logic got;
        exp_n     = (len == 10'd0) ? 192 : int'(len);
        clear_stage();
        cur_op    = op;
        res_delay = delay;
        b_alt     = alt;
        a_en      = 1'b1;
        b_en      = op_is_binary(op);
        send_cmd(op, len);
        check_val("cfg_next_cycle", arr_configs, op);
        check_val("busy_in_cfg", busy, 1);
        check_val("ss_low_in_cfg", arr_stage_start, 0);
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            #1;
            if (done) got = 1'b1;
        end
        check_val("done_seen", got, 1);
        repeat (3) @(negedge clk);
        #1;
        a_en = 1'b0;
        b_en = 1'b0;
        check_val("a_beats", at_cnt, exp_n);
        check_val("b_beats", bt_cnt, op_is_binary(op) ? exp_n : 0);
        if (!op_is_binary(op)) check_val("b_ready_unary", bready_cnt, 0);
        check_val("done_pulses", done_cnt, 1);
        check_val("results_sent", res_seen, exp_n);
        check_val("done_after_last_res", done_cyc - last_res_cyc, 2);
        check_val("ss_rise_gap", ss_rise - cmd_cyc, 3);
        check_val("first_beat_gap_ok", (first_at - ss_rise) >= 3, 1);
        check_val("qa_drained", qa.size(), 0);
        check_val("busy_after", busy, 0);
        check_val("cfg_held", arr_configs, op);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 4'd0;
        cmd_len   = 10'd0;
        clear_stage();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_cmd_ready", cmd_ready, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_ss", arr_stage_start, 0);
        check_val("rst_cfg", arr_configs, 0);
        check_val("rst_atvalid", arr_atvalid, 0);
        check_val("rst_err", err_op, 0);
        rst = 1'b0;
        #1;
        check_val("cmd_ready_rel", cmd_ready, 0);
        @(posedge clk);
        #1;
        check_val("cmd_ready_1cyc", cmd_ready, 1);

        // SILU, len 4, results 30 cycles after each beat
        run_cmd(OP_SILU, 10'd4, 1'b0, 30);

        // ADD, len 3, B valid every other cycle
        run_cmd(OP_ADD, 10'd3, 1'b1, 2);

        // Invalid op
        clear_stage();
        send_cmd(4'd7, 10'd2);
        check_val("err_pulse", err_op, 1);
        check_val("err_busy", busy, 0);
        @(posedge clk);
        #1;
        check_val("err_one_cycle", err_op, 0);
        check_val("err_ss", arr_stage_start, 0);
        check_val("err_cmd_ready", cmd_ready, 1);
        check_val("err_cfg_kept", arr_configs, OP_ADD);

        // MUL, len 0 -> DATA_NUM beats; then stray result strobes in IDLE
        run_cmd(OP_MUL, 10'd0, 1'b0, 5);
        done_cnt  = 0;
        extra_res = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        extra_res = 1'b0;
        check_val("stray_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        check_val("stray_done", done_cnt, 0);

        // Reset during FEED of GELU len 8 after 5 beats
        clear_stage();
        cur_op    = OP_GELU;
        res_delay = 100000;
        b_alt     = 1'b0;
        a_en      = 1'b1;
        send_cmd(OP_GELU, 10'd8);
        for (int i = 0; i < 200 && at_cnt < 5; i++) begin
            @(negedge clk);
            #1;
        end
        check_val("five_beats", at_cnt, 5);
        rst = 1'b1;
        #1;
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_ss", arr_stage_start, 0);
        check_val("mid_rst_atvalid", arr_atvalid, 0);
        check_val("mid_rst_a_ready", src_a_ready, 0);
        check_val("mid_rst_cmd_ready", cmd_ready, 0);
        check_val("mid_rst_cfg", arr_configs, 0);
        a_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("mid_rst_ready_back", cmd_ready, 1);
        repeat (4) @(posedge clk);
        #1;
        check_val("mid_rst_no_done", done_cnt, 0);

        // Fresh command completes normally
        run_cmd(OP_GELU, 10'd8, 1'b0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
